falling_char_scheduler: RTL and testbench
=========================================

// Module: falling_char_scheduler
// PURPOSE
//  Owns the falling-character slot table for the typing game: allocates slots for characters
//  from the random generator, advances every active slot once per frame, retires slots crossing
//  the bottom bound (miss), and clears slots matched by PS2 keystrokes (hit). Sits between
//  Generator/PS2 decoder and the VGA renderer, which reads slots through a read port.
// PARAMETERS
//  SLOTS     16   number of concurrent characters (power of 2, 2..64)
//  Y_BOUND   480  row at/after which an active character is a miss
//  MAX_MISS  8    misses that assert gameover (1..255)
// PORTS
//  clk          in   1    system clock (CLOCK_50 domain)
//  rst          in   1    synchronous, active-high reset
//  frame_tick   in   1    one-cycle pulse per VGA frame (v_addr wrap)
//  spawn_valid  in   1    generator offers a character
//  spawn_ready  out  1    scheduler accepts it this cycle
//  spawn_char   in   8    ASCII code
//  spawn_col    in   10   column (h pixel), 0..639
//  spawn_speed  in   3    rows per frame, 0..7
//  key_valid    in   1    one-cycle pulse, decoded keystroke
//  key_ascii    in   8    ASCII of keystroke
//  rd_idx       in   log2(SLOTS)  renderer slot select
//  rd_active/rd_char[8]/rd_col[10]/rd_row[10]  out  slot contents, combinational from rd_idx
//  hit_pulse, miss_pulse, key_drop  out 1  one-cycle event strobes
//  score        out  16   hits, saturating at 16'hFFFF
//  miss_cnt     out  8    misses, saturating at MAX_MISS
//  gameover     out  1    sticky until rst
// BEHAVIOUR
//  - Reset: all slots inactive, state IDLE, every output 0, pending flags cleared.
//  - FSM: IDLE, SWEEP, MATCH, OVER. spawn handled inside IDLE (single cycle, no state).
//  - frame_tick sets tick_pend (extra ticks while pending are merged). key_valid loads a
//    1-deep key buffer; key_valid with buffer full -> key dropped, key_drop pulses same cycle.
//  - IDLE priority: tick_pend > key buffer > spawn. tick_pend -> SWEEP, ptr=0, clear pend.
//    key buffer -> MATCH, ptr=0. spawn_ready = IDLE & !tick_pend & !keybuf_full & free slot
//    exists & !gameover; on handshake lowest-index free slot gets char/col/row=0/speed, active=1.
//  - SWEEP: one slot per cycle, SLOTS cycles. Active slot: sum = row + speed (11-bit);
//    sum >= Y_BOUND -> slot inactive, miss_pulse, miss_cnt++; else row <= sum[9:0].
//    After last slot: miss_cnt == MAX_MISS -> OVER, else IDLE. Multiple misses in one sweep
//    each pulse on their own cycle.
//  - MATCH: scans slots lowest-first; first active slot with char == key clears it,
//    hit_pulse, score++, buffer freed, -> IDLE immediately. No match after SLOTS cycles ->
//    buffer freed, IDLE, no pulse. Only one slot cleared per keystroke.
//  - OVER: gameover=1, slot table frozen (renderer still reads it), spawn_ready=0,
//    ticks/keys ignored (no key_drop). Only rst leaves OVER.
//  - rst mid-SWEEP/MATCH aborts the scan; table fully cleared next cycle.
//  - speed 0 slots never move; col is stored, never checked.
// CONFIGURATION
//  FCS_LEVEL_SPEEDUP_EN defined: 3-bit level register increments (saturating at 7) every
//  16 hits; SWEEP uses sum = row + speed + level. Undefined: level absent, sum = row + speed.
// STRUCTURE
//  Package char_sched_pkg: state enum, SLOT_W/ROW_W/COL_W widths, slot record typedef.
//  Sub-module char_slot_table: SLOTS-entry register file, one write port (FSM) plus the
//  async read port for the renderer and a second read port for the FSM scan pointer.
// TESTING
//  Spawn 'A' col 100 speed 3, 10 frame_ticks -> rd_row=30, rd_active=1, no miss_pulse.
//  Speed 7 slot, run to row 476, next tick -> miss_pulse, slot inactive, miss_cnt=1.
//  Two 'B' slots (idx 2,5), key 'B' -> only idx 2 cleared, score=1; key 'Z' -> no hit_pulse.
//  Fill all 16 slots -> spawn_ready=0; one miss frees slot -> next spawn lands in freed idx.
//  key_valid twice while SWEEP busy -> second pulses key_drop, first matched after sweep.
//  8 misses -> gameover=1, spawn_ready=0, ticks leave rows unchanged; rst -> all cleared.

Source files
------------

// File: rtl/char_sched_pkg.sv
// Shared types for the falling-character scheduler: FSM states, slot record, field widths.
package char_sched_pkg;

    localparam int CHAR_W = 8;
    localparam int COL_W  = 10;
    localparam int ROW_W  = 10;
    localparam int SPD_W  = 3;
    localparam int SUM_W  = ROW_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_MATCH = 2'd2,
        ST_OVER  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic              active;
        logic [CHAR_W-1:0] ch;
        logic [COL_W-1:0]  col;
        logic [ROW_W-1:0]  row;
        logic [SPD_W-1:0]  speed;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    // Index of the lowest clear bit; callers check that one exists.
    function automatic int lowest_clear(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (!v[i]) idx = i;
            else       idx = idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/char_slot_table.sv
// Slot register file: one write port, a renderer read port and a scan read port.
module char_slot_table
    import char_sched_pkg::*;
#(
    parameter  int SLOTS = 16,
    localparam int IDX_W = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  slot_t             wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_active_o,
    output logic [CHAR_W-1:0] rd_char_o,
    output logic [COL_W-1:0]  rd_col_o,
    output logic [ROW_W-1:0]  rd_row_o,
    input  logic [IDX_W-1:0]  scan_idx_i,
    output slot_t             scan_data_o,
    output logic [SLOTS-1:0]  active_o
);

    slot_t [SLOTS-1:0] mem_q;

    // Slot storage; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign rd_active_o = mem_q[rd_idx_i].active;
    assign rd_char_o   = mem_q[rd_idx_i].ch;
    assign rd_col_o    = mem_q[rd_idx_i].col;
    assign rd_row_o    = mem_q[rd_idx_i].row;
    assign scan_data_o = mem_q[scan_idx_i];

    // Occupancy vector for free-slot search.
    always_comb begin
        active_o = '0;
        for (int i = 0; i < SLOTS; i++) begin
            active_o[i] = mem_q[i].active;
        end
    end

endmodule

// File: rtl/falling_char_scheduler.sv
// Falling-character slot scheduler: spawn, per-frame sweep, keystroke match, game over.
// Optional FCS_LEVEL_SPEEDUP_EN adds a hit-driven level to every fall step.
module falling_char_scheduler
    import char_sched_pkg::*;
#(
    parameter  int SLOTS    = 16,
    parameter  int Y_BOUND  = 480,
    parameter  int MAX_MISS = 8,
    localparam int IDX_W    = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              spawn_valid,
    output logic              spawn_ready,
    input  logic [CHAR_W-1:0] spawn_char,
    input  logic [COL_W-1:0]  spawn_col,
    input  logic [SPD_W-1:0]  spawn_speed,
    input  logic              key_valid,
    input  logic [CHAR_W-1:0] key_ascii,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_active,
    output logic [CHAR_W-1:0] rd_char,
    output logic [COL_W-1:0]  rd_col,
    output logic [ROW_W-1:0]  rd_row,
    output logic              hit_pulse,
    output logic              miss_pulse,
    output logic              key_drop,
    output logic [15:0]       score,
    output logic [7:0]        miss_cnt,
    output logic              gameover
);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              tick_pend_q, tick_pend_d;
    logic              keybuf_full_q, keybuf_full_d;
    logic [CHAR_W-1:0] keybuf_q, keybuf_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic [15:0]       score_q, score_d;
    logic [7:0]        miss_cnt_q, miss_cnt_d;
    logic              gameover_q;

    logic              wr_en_s;
    logic [IDX_W-1:0]  wr_idx_s;
    slot_t             wr_data_s;
    slot_t             scan_data_s;
    logic [SLOTS-1:0]  active_s;
    logic              free_found_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic [SUM_W-1:0]  sum_s;
    logic              last_slot_s;

    char_slot_table #(.SLOTS(SLOTS)) u_table (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en_s),
        .wr_idx_i   (wr_idx_s),
        .wr_data_i  (wr_data_s),
        .rd_idx_i   (rd_idx),
        .rd_active_o(rd_active),
        .rd_char_o  (rd_char),
        .rd_col_o   (rd_col),
        .rd_row_o   (rd_row),
        .scan_idx_i (ptr_q),
        .scan_data_o(scan_data_s),
        .active_o   (active_s)
    );

    assign free_found_s = ~&active_s;
    assign free_idx_s   = IDX_W'(lowest_clear(64'(active_s)));
    assign last_slot_s  = (ptr_q == IDX_W'(SLOTS - 1));

    // Next-state, table write and strobe logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        tick_pend_d   = tick_pend_q;
        keybuf_full_d = keybuf_full_q;
        keybuf_d      = keybuf_q;
        hit_d         = 1'b0;
        miss_d        = 1'b0;
        score_d       = score_q;
        miss_cnt_d    = miss_cnt_q;
        wr_en_s       = 1'b0;
        wr_idx_s      = ptr_q;
        wr_data_s     = scan_data_s;
        spawn_ready   = 1'b0;
        key_drop      = 1'b0;

        // Ticks and keys are captured in every state except OVER.
        if (!rst && (state_q != ST_OVER)) begin
            if (frame_tick) tick_pend_d = 1'b1;
            else            tick_pend_d = tick_pend_q;
            if (key_valid && keybuf_full_q) begin
                key_drop = 1'b1;
            end else if (key_valid) begin
                keybuf_full_d = 1'b1;
                keybuf_d      = key_ascii;
            end else begin
                keybuf_full_d = keybuf_full_q;
            end
        end else begin
            tick_pend_d = tick_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_pend_q) begin
                    state_d     = ST_SWEEP;
                    ptr_d       = '0;
                    tick_pend_d = frame_tick;
                end else if (keybuf_full_q) begin
                    state_d = ST_MATCH;
                    ptr_d   = '0;
                end else begin
                    spawn_ready = !rst && free_found_s && !gameover_q;
                    if (spawn_valid && spawn_ready) begin
                        wr_en_s   = 1'b1;
                        wr_idx_s  = free_idx_s;
                        wr_data_s = '{active: 1'b1, ch: spawn_char, col: spawn_col,
                                      row: '0, speed: spawn_speed};
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
            end
            ST_SWEEP: begin
                if (scan_data_s.active && (sum_s >= SUM_W'(Y_BOUND))) begin
                    wr_en_s          = 1'b1;
                    wr_data_s.active = 1'b0;
                    miss_d           = 1'b1;
                    if (miss_cnt_q < 8'(MAX_MISS)) miss_cnt_d = miss_cnt_q + 8'd1;
                    else                           miss_cnt_d = miss_cnt_q;
                end else if (scan_data_s.active) begin
                    wr_en_s       = 1'b1;
                    wr_data_s.row = sum_s[ROW_W-1:0];
                end else begin
                    wr_en_s = 1'b0;
                end
                if (last_slot_s) begin
                    state_d = (miss_cnt_d == 8'(MAX_MISS)) ? ST_OVER : ST_IDLE;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            ST_MATCH: begin
                if (scan_data_s.active && (scan_data_s.ch == keybuf_q)) begin
                    wr_en_s          = 1'b1;
                    wr_data_s.active = 1'b0;
                    hit_d            = 1'b1;
                    keybuf_full_d    = 1'b0;
                    state_d          = ST_IDLE;
                    if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                    else                     score_d = score_q;
                end else if (last_slot_s) begin
                    keybuf_full_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef FCS_LEVEL_SPEEDUP_EN
    logic [2:0] level_q, level_d;

    // Level steps up on every 16th hit and holds at 7.
    always_comb begin
        if (hit_d && (score_q[3:0] == 4'hF) && (level_q != 3'd7)) level_d = level_q + 3'd1;
        else                                                     level_d = level_q;
    end

    // Level register.
    always_ff @(posedge clk) begin
        if (rst) level_q <= 3'd0;
        else     level_q <= level_d;
    end

    assign sum_s = SUM_W'(scan_data_s.row) + SUM_W'(scan_data_s.speed) + SUM_W'(level_q);
`else
    assign sum_s = SUM_W'(scan_data_s.row) + SUM_W'(scan_data_s.speed);
`endif

    // Control state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            tick_pend_q   <= 1'b0;
            keybuf_full_q <= 1'b0;
            keybuf_q      <= '0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            score_q       <= 16'd0;
            miss_cnt_q    <= 8'd0;
            gameover_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tick_pend_q   <= tick_pend_d;
            keybuf_full_q <= keybuf_full_d;
            keybuf_q      <= keybuf_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            score_q       <= score_d;
            miss_cnt_q    <= miss_cnt_d;
            gameover_q    <= (state_d == ST_OVER);
        end
    end

    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign miss_cnt   = miss_cnt_q;
    assign gameover   = gameover_q;

endmodule

// File: tb/tb_falling_char_scheduler.sv
// Randomized and directed bench for falling_char_scheduler against a slot-table model.
module tb_falling_char_scheduler;

    localparam int SLOTS    = 16;
    localparam int Y_BOUND  = 480;
    localparam int MAX_MISS = 8;
    localparam int SETTLE   = SLOTS + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       spawn_valid = 1'b0;
    logic       spawn_ready;
    logic [7:0] spawn_char = 8'd0;
    logic [9:0] spawn_col = 10'd0;
    logic [2:0] spawn_speed = 3'd0;
    logic       key_valid = 1'b0;
    logic [7:0] key_ascii = 8'd0;
    logic [3:0] rd_idx = 4'd0;
    logic       rd_active;
    logic [7:0] rd_char;
    logic [9:0] rd_col;
    logic [9:0] rd_row;
    logic       hit_pulse, miss_pulse, key_drop;
    logic [15:0] score;
    logic [7:0] miss_cnt;
    logic       gameover;

    falling_char_scheduler #(.SLOTS(SLOTS), .Y_BOUND(Y_BOUND), .MAX_MISS(MAX_MISS)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_char(spawn_char),
        .spawn_col(spawn_col), .spawn_speed(spawn_speed),
        .key_valid(key_valid), .key_ascii(key_ascii),
        .rd_idx(rd_idx), .rd_active(rd_active), .rd_char(rd_char), .rd_col(rd_col), .rd_row(rd_row),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .key_drop(key_drop),
        .score(score), .miss_cnt(miss_cnt), .gameover(gameover)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_hit = 0, n_miss = 0, n_drop = 0;
    int e_hit = 0, e_miss = 0, e_drop = 0;
    int m_act [SLOTS];
    int m_chr [SLOTS];
    int m_col [SLOTS];
    int m_row [SLOTS];
    int m_spd [SLOTS];
    int m_score = 0, m_miss = 0, m_over = 0;
    logic last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe counting and per-cycle exclusivity.
    always @(negedge clk) begin
        if (!rst) begin
            if (hit_pulse)  n_hit++;
            if (miss_pulse) n_miss++;
            if (key_drop)   n_drop++;
            total++;
            if ((hit_pulse && miss_pulse) || (gameover && spawn_ready)) begin
                bad++;
                $display("FAIL strobe_excl: hit=%0b miss=%0b gameover=%0b ready=%0b expected no overlap",
                         hit_pulse, miss_pulse, gameover, spawn_ready);
            end
        end
    end

    function automatic void m_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_act[i] = 0; m_chr[i] = 0; m_col[i] = 0; m_row[i] = 0; m_spd[i] = 0;
        end
        m_score = 0; m_miss = 0; m_over = 0;
        e_hit = 0; e_miss = 0; e_drop = 0;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < SLOTS; i++) if (m_act[i] == 0) return i;
        return -1;
    endfunction

    function automatic void m_tick();
        int lvl;
        lvl = 0;
`ifdef FCS_LEVEL_SPEEDUP_EN
        lvl = (m_score / 16 > 7) ? 7 : m_score / 16;
`endif
        if (m_over != 0) return;
        for (int i = 0; i < SLOTS; i++) begin
            if (m_act[i] != 0) begin
                if (m_row[i] + m_spd[i] + lvl >= Y_BOUND) begin
                    m_act[i] = 0;
                    e_miss++;
                    if (m_miss < MAX_MISS) m_miss++;
                end else begin
                    m_row[i] = m_row[i] + m_spd[i] + lvl;
                end
            end
        end
        if (m_miss == MAX_MISS) m_over = 1;
    endfunction

    function automatic void m_key(input int k);
        if (m_over != 0) return;
        for (int i = 0; i < SLOTS; i++) begin
            if (m_act[i] != 0 && m_chr[i] == k) begin
                m_act[i] = 0;
                m_score++;
                e_hit++;
                return;
            end
        end
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0; key_valid = 1'b0;
        @(negedge clk);
        chk("rst_spawn_ready", spawn_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        n_hit = 0; n_miss = 0; n_drop = 0;
    endtask

    task automatic op_spawn(input int c, input int col, input int spd);
        int slot;
        slot = m_free();
        @(posedge clk); #1;
        spawn_valid = 1'b1; spawn_char = 8'(c); spawn_col = 10'(col); spawn_speed = 3'(spd);
        @(negedge clk);
        last_ready = spawn_ready;
        chk("spawn_ready", spawn_ready, (m_over == 0 && slot >= 0));
        @(posedge clk); #1;
        spawn_valid = 1'b0;
        if (m_over == 0 && slot >= 0) begin
            m_act[slot] = 1; m_chr[slot] = c; m_col[slot] = col; m_row[slot] = 0; m_spd[slot] = spd;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic op_tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        m_tick();
        repeat (SETTLE) @(posedge clk);
    endtask

    task automatic op_key(input int k);
        @(posedge clk); #1 key_valid = 1'b1; key_ascii = 8'(k);
        @(posedge clk); #1 key_valid = 1'b0;
        m_key(k);
        repeat (SETTLE) @(posedge clk);
    endtask

    task automatic read_slot(input int i);
        @(negedge clk);
        rd_idx = 4'(i);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_score"}, score, m_score);
        chk({tag, "_miss_cnt"}, miss_cnt, m_miss);
        chk({tag, "_gameover"}, gameover, m_over);
        chk({tag, "_hits"}, n_hit, e_hit);
        chk({tag, "_misses"}, n_miss, e_miss);
        chk({tag, "_drops"}, n_drop, e_drop);
        for (int i = 0; i < SLOTS; i++) begin
            read_slot(i);
            chk($sformatf("%s_act%0d", tag, i), rd_active, m_act[i]);
            if (m_act[i] != 0) begin
                chk($sformatf("%s_chr%0d", tag, i), rd_char, m_chr[i]);
                chk($sformatf("%s_col%0d", tag, i), rd_col, m_col[i]);
                chk($sformatf("%s_row%0d", tag, i), rd_row, m_row[i]);
            end
        end
    endtask

    initial begin
        m_reset();
        do_reset();
        chk("reset_score", score, 0);
        chk("reset_gameover", gameover, 0);
        check_all("reset");

        // Steady fall: speed 3 over 10 frames.
        op_spawn(65, 100, 3);
        repeat (10) op_tick();
        read_slot(0);
        chk("fall_row", rd_row, 30);
        chk("fall_active", rd_active, 1);
        chk("fall_col", rd_col, 100);
        chk("fall_misses", n_miss, 0);
        check_all("fall");

        // Bottom bound: 476 + 7 crosses 480.
        do_reset();
        op_spawn(77, 5, 7);
        repeat (68) op_tick();
        read_slot(0);
        chk("bound_row", rd_row, 476);
        op_tick();
        read_slot(0);
        chk("bound_active", rd_active, 0);
        chk("bound_miss_cnt", miss_cnt, 1);
        chk("bound_pulses", n_miss, 1);
        check_all("bound");

        // Duplicate chars: only the lowest index is hit.
        do_reset();
        for (int i = 0; i < 6; i++) op_spawn((i == 2 || i == 5) ? 66 : 81 + i, 10 * i, 0);
        op_key(66);
        chk("dup_score", score, 1);
        read_slot(2);
        chk("dup_idx2", rd_active, 0);
        read_slot(5);
        chk("dup_idx5", rd_active, 1);
        op_key(90);
        chk("nomatch_hits", n_hit, 1);
        check_all("dup");

        // Full table, then a miss frees slot 7.
        do_reset();
        for (int i = 0; i < SLOTS; i++) op_spawn(97 + i, i, (i == 7) ? 7 : 0);
        op_spawn(78, 1, 1);
        chk("full_ready", last_ready, 0);
        repeat (69) op_tick();
        op_spawn(78, 300, 2);
        read_slot(7);
        chk("refill_char", rd_char, 78);
        chk("refill_active", rd_active, 1);
        check_all("refill");

        // Two keys while a sweep is busy: second is dropped, first matched later.
        do_reset();
        op_spawn(75, 20, 1);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0; key_valid = 1'b1; key_ascii = 8'd75;
        @(posedge clk); #1 key_ascii = 8'd80;
        @(negedge clk);
        chk("busy_key_drop", key_drop, 1);
        @(posedge clk); #1 key_valid = 1'b0;
        m_tick(); m_key(75); e_drop++;
        repeat (2 * SETTLE) @(posedge clk);
        chk("busy_score", score, 1);
        chk("busy_drops", n_drop, 1);
        check_all("busy");

        // Eight misses in one sweep end the game; table then frozen.
        do_reset();
        for (int i = 0; i < 8; i++) op_spawn(48 + i, i, 7);
        op_spawn(105, 50, 2);
        repeat (69) op_tick();
        chk("over_gameover", gameover, 1);
        chk("over_miss_cnt", miss_cnt, 8);
        op_spawn(106, 0, 1);
        chk("over_ready", last_ready, 0);
        op_tick();
        read_slot(8);
        chk("over_frozen_row", rd_row, 138);
        @(posedge clk); #1 key_valid = 1'b1; key_ascii = 8'd105;
        @(posedge clk); #1;
        @(negedge clk);
        chk("over_no_drop", key_drop, 0);
        @(posedge clk); #1 key_valid = 1'b0;
        repeat (SETTLE) @(posedge clk);
        chk("over_score", score, 0);
        check_all("over");
        do_reset();
        check_all("post_over");

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_over != 0 && r < 25) do_reset();
            else if (r < 45) op_tick();
            else if (r < 75) op_spawn(65 + $urandom_range(0, 3), $urandom_range(0, 639), $urandom_range(0, 7));
            else op_key(65 + $urandom_range(0, 4));
            if (n % 4 == 3) check_all("rnd");
        end
        check_all("rnd_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
